// File: rtl/count_ctrl_if.sv
// Control/status bundle between test/control logic and the count_ctrl sequencer.
// The dir signal exists only when COUNT_CTRL_DOWN_EN is defined.
interface count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic             auto_reload;
    logic             tick_en;
`ifdef COUNT_CTRL_DOWN_EN
    logic             dir;
`endif
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, load, load_val, limit, auto_reload, tick_en,
`ifdef COUNT_CTRL_DOWN_EN
        output dir,
`endif
        input  count, tc, busy, done
    );

    modport slave (
        input  start, stop, load, load_val, limit, auto_reload, tick_en,
`ifdef COUNT_CTRL_DOWN_EN
        input  dir,
`endif
        output count, tc, busy, done
    );
endinterface

// File: rtl/count_ctrl.sv
// Start/pause/load/stop sequencer for a WIDTH-bit counter with terminal-count detect; down-count via COUNT_CTRL_DOWN_EN.
// Latency: every output is registered, one clock from command/tick to visible effect.
// Backpressure: none; commands and ticks are sampled every cycle (stop > load > start).
module count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    count_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             terminal;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] base_val;

    // Direction picks the terminal value, step direction and the reload/start value.
`ifdef COUNT_CTRL_DOWN_EN
    always_comb begin
        terminal   = bus.dir ? (count_q == '0) : (count_q == bus.limit);
        next_count = bus.dir ? (count_q - 1'b1) : (count_q + 1'b1);
        base_val   = bus.dir ? bus.limit : '0;
    end
`else
    always_comb begin
        terminal   = (count_q == bus.limit);
        next_count = count_q + 1'b1;
        base_val   = '0;
    end
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (bus.load) begin
                    count_d = bus.load_val;
                end else if (bus.start) begin
                    state_d = ST_RUN;
                    count_d = base_val;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_HOLD;
                end else if (bus.load) begin
                    count_d = bus.load_val;
                end else if (bus.tick_en) begin
                    if (terminal) begin
                        tc_d = 1'b1;
                        if (bus.auto_reload) count_d = base_val;
                        else                 state_d = ST_DONE;
                    end else begin
                        count_d = next_count;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (bus.load) begin
                    count_d = bus.load_val;
                end else if (bus.start) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (bus.load) begin
                    state_d = ST_HOLD;
                    count_d = bus.load_val;
                end else if (bus.start) begin
                    state_d = ST_RUN;
                    count_d = base_val;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Status flags track the next state so they change on the same edge as tc.
        busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl, WIDTH=4, with hand-computed expectations.
module tb_count_ctrl;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    count_ctrl_if #(.WIDTH(WIDTH)) bus ();

    count_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp_c[9]  = '{1, 1, 2, 2, 3, 3, 0, 0, 1};
    int exp_tc[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.load         = 1'b0;
        bus.load_val     = '0;
        bus.limit        = '0;
        bus.auto_reload  = 1'b0;
        bus.tick_en      = 1'b0;
`ifdef COUNT_CTRL_DOWN_EN
        bus.dir          = 1'b0;
`endif
        step();
        step();
        check("rst_count", bus.count, 0);
        check("rst_tc",    bus.tc,    0);
        check("rst_busy",  bus.busy,  0);
        check("rst_done",  bus.done,  0);
        rst = 1'b0;

        // limit=0: first qualified tick is terminal, count stays 0
        bus.start = 1'b1;
        bus.tick_en = 1'b1;
        step();
        bus.start = 1'b0;
        check("lim0_start_count", bus.count, 0);
        step();
        check("lim0_tc",    bus.tc,    1);
        check("lim0_done",  bus.done,  1);
        check("lim0_count", bus.count, 0);

        // Basic run to limit=5, halt in DONE
        bus.limit = 4'd5;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("run_start_count", bus.count, 0);
        check("run_start_busy",  bus.busy,  1);
        check("run_start_done",  bus.done,  0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("run_count_%0d", i), bus.count, i);
            check($sformatf("run_tc_%0d", i),    bus.tc,    0);
        end
        step();
        check("term_tc",    bus.tc,    1);
        check("term_done",  bus.done,  1);
        check("term_busy",  bus.busy,  0);
        check("term_count", bus.count, 5);
        step();
        check("post_tc",    bus.tc,    0);
        check("post_count", bus.count, 5);
        check("post_done",  bus.done,  1);

        // limit=3 auto_reload, tick_en toggling
        bus.limit = 4'd3;
        bus.auto_reload = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("ar_start_count", bus.count, 0);
        for (int k = 0; k < 9; k++) begin
            bus.tick_en = (k % 2 == 0);
            step();
            check($sformatf("ar_count_%0d", k), bus.count, exp_c[k]);
            check($sformatf("ar_tc_%0d", k),    bus.tc,    exp_tc[k]);
        end
        check("ar_busy", bus.busy, 1);

        // Pause at 2, hold 10 cycles, resume, double stop
        bus.tick_en = 1'b1;
        step();
        check("pause_pre", bus.count, 2);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("pause_count", bus.count, 2);
        check("pause_busy",  bus.busy,  1);
        repeat (10) step();
        check("pause_frozen", bus.count, 2);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("resume_edge", bus.count, 2);
        step();
        check("resume_count", bus.count, 3);
        bus.stop = 1'b1;
        step();
        check("stop1_count", bus.count, 3);
        check("stop1_busy",  bus.busy,  1);
        step();
        bus.stop = 1'b0;
        check("stop2_count", bus.count, 0);
        check("stop2_busy",  bus.busy,  0);
        check("stop2_done",  bus.done,  0);

        // stop beats load and start in RUN
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        check("prio_pre", bus.count, 1);
        bus.start = 1'b1;
        bus.stop = 1'b1;
        bus.load = 1'b1;
        bus.load_val = 4'd9;
        step();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.load = 1'b0;
        check("prio_count", bus.count, 1);
        check("prio_busy",  bus.busy,  1);
        step();
        check("prio_hold", bus.count, 1);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("prio_idle", bus.count, 0);

        // load 14 above limit=2: wraps through 15 -> 0 before terminal
        bus.limit = 4'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.load = 1'b1;
        bus.load_val = 4'd14;
        step();
        bus.load = 1'b0;
        check("ld_count", bus.count, 14);
        check("ld_tc",    bus.tc,    0);
        step(); check("ld_15", bus.count, 15);
        step(); check("ld_0",  bus.count, 0);
        step(); check("ld_1",  bus.count, 1);
        step(); check("ld_2",  bus.count, 2);
        check("ld_2_tc", bus.tc, 0);
        step();
        check("ld_term_tc",    bus.tc,    1);
        check("ld_term_count", bus.count, 0);

        // Asynchronous reset mid-count at 7
        bus.limit = 4'd15;
        bus.auto_reload = 1'b0;
        repeat (7) step();
        check("ar7_count", bus.count, 7);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", bus.count, 0);
        check("arst_busy",  bus.busy,  0);
        check("arst_tc",    bus.tc,    0);
        check("arst_done",  bus.done,  0);
        step();
        rst = 1'b0;
        step();
        check("arst_idle_count", bus.count, 0);
        check("arst_idle_busy",  bus.busy,  0);

`ifdef COUNT_CTRL_DOWN_EN
        // Down count with reload to limit
        bus.dir = 1'b1;
        bus.limit = 4'd4;
        bus.auto_reload = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("dn_start", bus.count, 4);
        for (int v = 3; v >= 0; v--) begin
            step();
            check($sformatf("dn_count_%0d", v), bus.count, v);
            check($sformatf("dn_tc_%0d", v),    bus.tc,    0);
        end
        step();
        check("dn_reload_count", bus.count, 4);
        check("dn_reload_tc",    bus.tc,    1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
